// File: rtl/exu_oitf.sv
// exu_oitf: outstanding instruction track FIFO for long-latency ops.
// Ports: dis_* allocate, ret_* retire head, chk_*/dep hazard query, empty/full/count status.
module exu_oitf #(
    parameter int DEPTH       = 4,
    parameter int RFIDX_WIDTH = 5,
    parameter int PC_SIZE     = 32,
    localparam int PTR_W      = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   dis_ena,
    output logic                   dis_ready,
    input  logic                   dis_rdwen,
    input  logic [RFIDX_WIDTH-1:0] dis_rdidx,
    input  logic [PC_SIZE-1:0]     dis_pc,
    output logic [PTR_W-1:0]       dis_ptr,
    input  logic                   ret_ena,
    output logic [PTR_W-1:0]       ret_ptr,
    output logic                   ret_rdwen,
    output logic [RFIDX_WIDTH-1:0] ret_rdidx,
    output logic [PC_SIZE-1:0]     ret_pc,
    input  logic                   chk_rs1en,
    input  logic                   chk_rs2en,
    input  logic                   chk_rdwen,
    input  logic [RFIDX_WIDTH-1:0] chk_rs1idx,
    input  logic [RFIDX_WIDTH-1:0] chk_rs2idx,
    input  logic [RFIDX_WIDTH-1:0] chk_rdidx,
    output logic                   dep,
    output logic                   empty,
    output logic                   full,
    output logic [PTR_W:0]         count
);

    localparam logic [PTR_W:0] PTR_ONE = 1;

    // Top bit of each pointer is the wrap flag.
    logic [PTR_W:0]         wr_q;
    logic [PTR_W:0]         rd_q;
    logic [DEPTH-1:0]       vld_q;
    logic [DEPTH-1:0]       rdwen_q;
    logic [RFIDX_WIDTH-1:0] rdidx_q [DEPTH];
    logic [PC_SIZE-1:0]     pc_q    [DEPTH];

    logic alloc;
    logic retire;

    assign dis_ptr   = wr_q[PTR_W-1:0];
    assign ret_ptr   = rd_q[PTR_W-1:0];
    assign empty     = (wr_q == rd_q);
    assign full      = (wr_q[PTR_W-1:0] == rd_q[PTR_W-1:0])
                    && (wr_q[PTR_W] != rd_q[PTR_W]);
    assign count     = wr_q - rd_q;
    assign dis_ready = !full;

    // Status comes from registered state, so a retire in a full cycle
    // cannot open a slot for an allocation in that same cycle.
    assign alloc  = dis_ena && !full;
    assign retire = ret_ena && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            vld_q <= '0;
        end else if (flush) begin
            wr_q  <= '0;
            rd_q  <= '0;
            vld_q <= '0;
        end else begin
            if (alloc) begin
                wr_q                      <= wr_q + PTR_ONE;
                vld_q[wr_q[PTR_W-1:0]]    <= 1'b1;
            end
            if (retire) begin
                rd_q                      <= rd_q + PTR_ONE;
                vld_q[rd_q[PTR_W-1:0]]    <= 1'b0;
            end
        end
    end

    // Payload is qualified by vld_q, so it needs no reset.
    always_ff @(posedge clk) begin
        if (alloc) begin
            rdwen_q[wr_q[PTR_W-1:0]] <= dis_rdwen;
            rdidx_q[wr_q[PTR_W-1:0]] <= dis_rdidx;
            pc_q[wr_q[PTR_W-1:0]]    <= dis_pc;
        end
    end

    always_comb begin
        ret_rdwen = 1'b0;
        ret_rdidx = '0;
        ret_pc    = '0;
        if (!empty) begin
            ret_rdwen = rdwen_q[rd_q[PTR_W-1:0]];
            ret_rdidx = rdidx_q[rd_q[PTR_W-1:0]];
            ret_pc    = pc_q[rd_q[PTR_W-1:0]];
        end
    end

    // x0 writes never create a hazard.
    always_comb begin
        dep = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && rdwen_q[i] && (rdidx_q[i] != '0)) begin
                if ((chk_rs1en && (chk_rs1idx == rdidx_q[i]))
                 || (chk_rs2en && (chk_rs2idx == rdidx_q[i]))
                 || (chk_rdwen && (chk_rdidx  == rdidx_q[i])))
                    dep = 1'b1;
            end
        end
    end

endmodule
